// File: rtl/iiitb_sdmoore_param_if.sv
// Serial-detector bus: data/control towards the detector, match status back.
interface iiitb_sdmoore_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             overlap;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output din, din_valid, overlap, pat_load, pat_in, cnt_clr,
    input  y, match_cnt, cnt_sat
  );

  modport slave (
    input  din, din_valid, overlap, pat_load, pat_in, cnt_clr,
    output y, match_cnt, cnt_sat
  );
endinterface

// File: rtl/iiitb_sdmoore_param.sv
// Moore serial sequence detector with loadable pattern, overlap mode and
// saturating match counter.
module iiitb_sdmoore_param #(
  parameter int           N        = 4,
  parameter logic [N-1:0] PAT_INIT = 4'b1010,
  parameter int           CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  iiitb_sdmoore_param_if.slave bus
);
  localparam int FW = $clog2(N + 1);

  logic [N-1:0]     pat, nxt_pat;
  logic [N-1:0]     hist, nxt_hist;
  logic [FW-1:0]    fill, nxt_fill;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             sat, nxt_sat;
  logic             y_now, y_nxt, accept, inc;

  assign y_now = (fill == FW'(N)) && (hist == pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= PAT_INIT;
      hist <= '0;
      fill <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else begin
      pat  <= nxt_pat;
      hist <= nxt_hist;
      fill <= nxt_fill;
      cnt  <= nxt_cnt;
      sat  <= nxt_sat;
    end
  end

  always_comb begin
    nxt_pat  = pat;
    nxt_hist = hist;
    nxt_fill = fill;
    accept   = bus.din_valid && !bus.pat_load;

    if (bus.pat_load) begin
      nxt_pat  = bus.pat_in;
      nxt_hist = '0;
      nxt_fill = '0;
    end else if (bus.din_valid) begin
      if (y_now && !bus.overlap) begin
        // non-overlap: the bit after a match starts a fresh search
        nxt_hist    = '0;
        nxt_hist[0] = bus.din;
        nxt_fill    = FW'(1);
      end else begin
        nxt_hist = {hist[N-2:0], bus.din};
        nxt_fill = (fill == FW'(N)) ? fill : fill + FW'(1);
      end
    end

    y_nxt = (nxt_fill == FW'(N)) && (nxt_hist == nxt_pat);
    inc   = accept && y_nxt;

    nxt_cnt = cnt;
    nxt_sat = sat;
    if (bus.cnt_clr) begin
      nxt_cnt = '0;
      nxt_sat = 1'b0;
    end else if (inc && (cnt != '1)) begin
      nxt_cnt = cnt + CNT_W'(1);
      nxt_sat = sat | (nxt_cnt == '1);
    end
  end

  assign bus.y         = y_now;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat;
endmodule
